cam_request_sequencer: RTL and testbench



---
 rtl/cam_request_sequencer_if.sv | 37 +++
 rtl/cam_request_sequencer.sv | 140 ++++++++++++++
 tb/tb_cam_request_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_request_sequencer_if.sv
// Request, CAM-port and response signals of the CAM request sequencer.
// The slave side is the sequencer; the master side is its environment.
interface cam_request_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] req_addr;
    logic              cam_wen;
    logic              cam_ren;
    logic [DATA_W-1:0] cam_din;
    logic [ADDR_W-1:0] cam_addr;
    logic [ADDR_W-1:0] cam_dout;
    logic              cam_hit;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_index;
    logic [7:0]        hit_count;

    modport slave (
        input  req_valid, req_op, req_data, req_addr,
        input  cam_dout, cam_hit, rsp_ready,
        output req_ready, cam_wen, cam_ren, cam_din, cam_addr,
        output rsp_valid, rsp_hit, rsp_index, hit_count
    );

    modport master (
        output req_valid, req_op, req_data, req_addr,
        output cam_dout, cam_hit, rsp_ready,
        input  req_ready, cam_wen, cam_ren, cam_din, cam_addr,
        input  rsp_valid, rsp_hit, rsp_index, hit_count
    );
endinterface

// File: rtl/cam_request_sequencer.sv
// Queues CAM write/search requests and issues them as single-cycle
// wen/ren pulses; search results are returned on a response port.
module cam_request_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    cam_request_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    req_t             fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    state_t           state_d;
    logic             push;
    logic             pop;
    logic             empty;
    logic             capture;
    logic             rsp_done;
    req_t             head;

    assign empty         = (count == '0);
    assign bus.req_ready = rst_n & (count != CNT_W'(DEPTH));
    assign push          = bus.req_valid & bus.req_ready;
    assign head          = fifo_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{bus.req_op, bus.req_data, bus.req_addr};
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A pulse lasts exactly one cycle: the port registers load only on a pop.
    always_comb begin
        state_d  = state;
        pop      = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.cam_ren) begin
                    state_d = WAIT;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cam_wen  <= 1'b0;
            bus.cam_ren  <= 1'b0;
            bus.cam_din  <= '0;
            bus.cam_addr <= '0;
        end else if (pop) begin
            bus.cam_wen  <= ~head.op;
            bus.cam_ren  <= head.op;
            bus.cam_din  <= head.data;
            bus.cam_addr <= head.op ? '0 : head.addr;
        end else begin
            bus.cam_wen  <= 1'b0;
            bus.cam_ren  <= 1'b0;
            bus.cam_din  <= '0;
            bus.cam_addr <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_index <= '0;
            bus.hit_count <= '0;
        end else if (capture) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_hit   <= bus.cam_hit;
            bus.rsp_index <= bus.cam_hit ? bus.cam_dout : '0;
            if (bus.cam_hit && bus.hit_count != 8'hFF) begin
                bus.hit_count <= bus.hit_count + 8'd1;
            end
        end else if (rsp_done) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_index <= '0;
        end
    end
endmodule

// File: tb/tb_cam_request_sequencer.sv
// Bench for cam_request_sequencer: CAM environment, transaction-level
// timing model compared every cycle, plus directed literal checks.
module tb_cam_request_sequencer;
    localparam int DEPTH = 4;

    typedef struct packed {
        bit       op;
        bit [7:0] data;
        bit [3:0] addr;
    } mreq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    cam_request_sequencer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    cam_request_sequencer #(
        .DEPTH (DEPTH),
        .DATA_W(8),
        .ADDR_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // CAM environment: registered result, misses report index 0xF
    logic [7:0] cmem [16];
    bit         cval [16];
    logic       env_h;
    logic [3:0] env_i;

    initial begin
        for (int i = 0; i < 16; i++) cval[i] = 1'b0;
        bus.cam_dout = '0;
        bus.cam_hit  = 1'b0;
    end

    always @(posedge clk) begin
        if (bus.cam_wen) begin
            cmem[bus.cam_addr] <= bus.cam_din;
            cval[bus.cam_addr] <= 1'b1;
        end
        if (bus.cam_ren) begin
            env_h = 1'b0;
            env_i = 4'hF;
            for (int i = 0; i < 16; i++) begin
                if (cval[i] && cmem[i] == bus.cam_din) begin
                    env_h = 1'b1;
                    env_i = 4'(i);
                end
            end
            bus.cam_hit  <= env_h;
            bus.cam_dout <= env_i;
        end
    end

    // Model: requests queue; a pop needs an entry from an earlier edge,
    // writes allow the next pop one edge later, a search blocks popping
    // until the edge after its response handshake.
    mreq_t    q[$];
    mreq_t    r;
    bit [7:0] mmem [16];
    bit       mval [16];
    int       cyc = 0;
    int       next_ok = 0;
    int       rsp_due = 0;
    int       sz;
    bit       mpush;
    bit       inflight = 0;
    bit       rsp_act = 0;
    bit       pend_hit;
    bit [3:0] pend_idx;
    bit       e_wen = 0, e_ren = 0;
    bit [7:0] e_din = 0;
    bit [3:0] e_addr = 0;
    bit       e_rv = 0, e_rh = 0;
    bit [3:0] e_ri = 0;
    int       e_hc = 0;

    initial for (int i = 0; i < 16; i++) mval[i] = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            inflight = 0;
            rsp_act  = 0;
            next_ok  = 0;
            {e_wen, e_ren, e_din, e_addr} = '0;
            {e_rv, e_rh, e_ri} = '0;
            e_hc = 0;
        end else begin
            cyc++;
            sz    = q.size();
            mpush = bus.req_valid && (sz < DEPTH);
            if (rsp_act && bus.rsp_ready) begin
                rsp_act  = 0;
                inflight = 0;
                next_ok  = cyc + 1;
                {e_rv, e_rh, e_ri} = '0;
            end
            if (inflight && !rsp_act && cyc == rsp_due) begin
                rsp_act = 1;
                e_rv = 1;
                e_rh = pend_hit;
                e_ri = pend_idx;
                if (pend_hit && e_hc < 255) e_hc++;
            end
            {e_wen, e_ren, e_din, e_addr} = '0;
            if (sz > 0 && !inflight && cyc >= next_ok) begin
                r = q.pop_front();
                e_din = r.data;
                if (!r.op) begin
                    e_wen = 1;
                    e_addr = r.addr;
                    mmem[r.addr] = r.data;
                    mval[r.addr] = 1;
                    next_ok = cyc + 1;
                end else begin
                    e_ren = 1;
                    inflight = 1;
                    rsp_due = cyc + 2;
                    pend_hit = 0;
                    pend_idx = 0;
                    for (int i = 0; i < 16; i++) begin
                        if (mval[i] && mmem[i] == r.data) begin
                            pend_hit = 1;
                            pend_idx = 4'(i);
                        end
                    end
                end
            end
            if (mpush) q.push_back('{bus.req_op, bus.req_data, bus.req_addr});
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cam_wen", 32'(bus.cam_wen), 32'(e_wen));
            check("cam_ren", 32'(bus.cam_ren), 32'(e_ren));
            check("cam_din", 32'(bus.cam_din), 32'(e_din));
            check("cam_addr", 32'(bus.cam_addr), 32'(e_addr));
            check("req_ready", 32'(bus.req_ready),
                  32'(rst_n && q.size() < DEPTH));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            check("rsp_hit", 32'(bus.rsp_hit), 32'(e_rh));
            check("rsp_index", 32'(bus.rsp_index), 32'(e_ri));
            check("hit_count", 32'(bus.hit_count), 32'(e_hc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit op, input logic [7:0] d,
                        input logic [3:0] a);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = d;
        bus.req_addr  = a;
        while (!bus.req_ready && n < 60) begin
            tick();
            n++;
        end
        check("push_accept", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic hit, input logic [3:0] idx,
                            input logic [7:0] hc);
        int n = 0;
        while (!bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("wait_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("lit_rsp_hit", 32'(bus.rsp_hit), 32'(hit));
        check("lit_rsp_index", 32'(bus.rsp_index), 32'(idx));
        check("lit_hit_count", 32'(bus.hit_count), 32'(hc));
    endtask

    task automatic wait_wen();
        int n = 0;
        while (!bus.cam_wen && n < 20) begin
            tick();
            n++;
        end
        check("wait_cam_wen", 32'(bus.cam_wen), 32'd1);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_data  = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", 32'(bus.req_ready), 32'd1);
        check("rel_cam_wen", 32'(bus.cam_wen), 32'd0);
        tick();

        // write 5A@3 then search 5A: exact latency
        push(1'b0, 8'h5A, 4'd3);
        push(1'b1, 8'h5A, 4'd0);
        check("w1_wen", 32'(bus.cam_wen), 32'd1);
        check("w1_addr", 32'(bus.cam_addr), 32'd3);
        check("w1_din", 32'(bus.cam_din), 32'h5A);
        tick();
        tick();
        check("s1_not_yet", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("s1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("s1_rsp_hit", 32'(bus.rsp_hit), 32'd1);
        check("s1_rsp_index", 32'(bus.rsp_index), 32'd3);
        check("s1_hit_count", 32'(bus.hit_count), 32'd1);
        repeat (3) tick();

        // back-to-back writes, highest index wins, then a miss
        push(1'b0, 8'h11, 4'd2);
        push(1'b0, 8'h11, 4'd9);
        check("w2_addr", 32'(bus.cam_addr), 32'd2);
        push(1'b1, 8'h11, 4'd0);
        check("w3_wen", 32'(bus.cam_wen), 32'd1);
        check("w3_addr", 32'(bus.cam_addr), 32'd9);
        wait_rsp(1'b1, 4'd9, 8'd2);
        repeat (2) tick();
        push(1'b1, 8'h77, 4'd0);
        wait_rsp(1'b0, 4'd0, 8'd2);
        repeat (2) tick();

        // response back-pressure with a full FIFO
        bus.rsp_ready = 1'b0;
        push(1'b1, 8'h5A, 4'd0);
        wait_rsp(1'b1, 4'd3, 8'd3);
        push(1'b0, 8'h21, 4'd4);
        push(1'b0, 8'h22, 4'd5);
        push(1'b1, 8'h22, 4'd0);
        push(1'b0, 8'h23, 4'd6);
        check("full_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (6) tick();
        check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("hold_rsp_index", 32'(bus.rsp_index), 32'd3);
        bus.rsp_ready = 1'b1;
        wait_wen();
        check("ord1_addr", 32'(bus.cam_addr), 32'd4);
        check("ord1_din", 32'(bus.cam_din), 32'h21);
        tick();
        check("ord2_addr", 32'(bus.cam_addr), 32'd5);
        tick();
        check("ord3_ren", 32'(bus.cam_ren), 32'd1);
        check("ord3_din", 32'(bus.cam_din), 32'h22);
        wait_rsp(1'b1, 4'd5, 8'd4);
        repeat (6) tick();

        // saturation of hit_count
        for (int i = 0; i < 300; i++) push(1'b1, 8'h5A, 4'd0);
        repeat (10) tick();
        check("sat_hit_count", 32'(bus.hit_count), 32'd255);

        // reset while the search waits for the CAM result
        push(1'b1, 8'h11, 4'd0);
        n = 0;
        while (!bus.cam_ren && n < 20) begin
            tick();
            n++;
        end
        check("wait_cam_ren", 32'(bus.cam_ren), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("ar_req_ready", 32'(bus.req_ready), 32'd0);
        check("ar_hit_count", 32'(bus.hit_count), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("ar_no_rsp", 32'(bus.rsp_valid), 32'd0);
        push(1'b1, 8'h11, 4'd0);
        wait_rsp(1'b1, 4'd9, 8'd1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
